bp_raster_sweeper: RTL and testbench

//  Parametrised windowed raster engine for the BP video path. Sweeps any clipped rectangle one pixel per clock.

---
 rtl/bp_raster_sweeper_pkg.sv | 16 +
 rtl/bp_raster_sweeper_if.sv | 35 +++
 rtl/bp_raster_sweeper_delay_line.sv | 33 +++
 rtl/bp_raster_sweeper.sv | 163 ++++++++++++++++
 tb/tb_bp_raster_sweeper.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_raster_sweeper_pkg.sv
// Shared definitions for the BP raster sweeper: screen defaults, colours and FSM states.
package bp_raster_sweeper_pkg;

    localparam int unsigned SCR_W_DEF = 320;
    localparam int unsigned SCR_H_DEF = 240;

    localparam logic [2:0] BLACK = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/bp_raster_sweeper_if.sv
// Control, shader and vga_adapter plot signals of the raster sweeper.
interface bp_raster_sweeper_if #(
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 9,
    parameter int unsigned COL_W = 3
);
    logic             start;
    logic             abort;
    logic [X_W-1:0]   win_x0;
    logic [X_W-1:0]   win_x1;
    logic [Y_W-1:0]   win_y0;
    logic [Y_W-1:0]   win_y1;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [X_W-1:0]   px_x;
    logic [Y_W-1:0]   px_y;
    logic             px_valid;
    logic             sh_hit;
    logic [COL_W-1:0] sh_color;
    logic [X_W-1:0]   gun_x;
    logic [Y_W-1:0]   gun_y;
    logic [COL_W-1:0] gun_color;
    logic             gun_plot;

    modport master (
        output start, abort, win_x0, win_x1, win_y0, win_y1, sh_hit, sh_color,
        input  busy, done, aborted, px_x, px_y, px_valid, gun_x, gun_y, gun_color, gun_plot
    );

    modport slave (
        input  start, abort, win_x0, win_x1, win_y0, win_y1, sh_hit, sh_color,
        output busy, done, aborted, px_x, px_y, px_valid, gun_x, gun_y, gun_color, gun_plot
    );
endinterface

// File: rtl/bp_raster_sweeper_delay_line.sv
// Shift register aligning {valid,x,y} with the external shader; DEPTH=0 is a pass-through.
module bp_delay_line #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset_hard,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            // MSB is the valid bit; a flush must drop it even with no storage.
            assign q_o = {d_i[WIDTH-1] & ~flush_i, d_i[WIDTH-2:0]};
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge CLOCK_50 or negedge reset_hard) begin
                if (!reset_hard) begin
                    for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (flush_i) begin
                    for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/bp_raster_sweeper.sv
// Windowed raster engine: sweeps a clipped rectangle one pixel per clock through an
// external pipelined shader and drives the vga_adapter plot port.
module bp_raster_sweeper
    import bp_raster_sweeper_pkg::*;
#(
    parameter int unsigned SCR_W     = SCR_W_DEF,
    parameter int unsigned SCR_H     = SCR_H_DEF,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9,
    parameter int unsigned COL_W     = 3,
    parameter int unsigned SHADE_LAT = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset_hard,
    bp_raster_sweeper_if.slave  bus
);
    localparam logic [X_W-1:0] X_MAX     = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0] Y_MAX     = Y_W'(SCR_H - 1);
    localparam logic [2:0]     DRAIN_LEN = 3'(SHADE_LAT);
    localparam int unsigned    DL_W      = 1 + X_W + Y_W;

    sweep_state_e     state_q, state_d;
    logic [X_W-1:0]   x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [Y_W-1:0]   y_q, y_d, y1_q, y1_d;
    logic [2:0]       drain_q, drain_d;
    logic             aborted_q, aborted_d;
    logic [X_W-1:0]   cx0, cx1;
    logic [Y_W-1:0]   cy0, cy1;
    logic             flush;
    logic [DL_W-1:0]  dl_q;
    logic             dl_valid;
    logic [X_W-1:0]   dl_x;
    logic [Y_W-1:0]   dl_y;
    logic             gun_plot_d, gun_plot_q;
    logic [X_W-1:0]   gun_x_q;
    logic [Y_W-1:0]   gun_y_q;
    logic [COL_W-1:0] gun_color_q;

    always_comb begin
        cx0 = (bus.win_x0 > X_MAX) ? X_MAX : bus.win_x0;
        cx1 = (bus.win_x1 > X_MAX) ? X_MAX : bus.win_x1;
        cy0 = (bus.win_y0 > Y_MAX) ? Y_MAX : bus.win_y0;
        cy1 = (bus.win_y1 > Y_MAX) ? Y_MAX : bus.win_y1;
    end

    assign flush = bus.abort && (state_q == ST_SWEEP || state_q == ST_DRAIN);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        drain_d   = drain_q;
        aborted_d = aborted_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    x0_d      = cx0;
                    x1_d      = cx1;
                    y1_d      = cy1;
                    x_d       = cx0;
                    y_d       = cy0;
                    aborted_d = 1'b0;
                    state_d   = (cx0 > cx1 || cy0 > cy1) ? ST_DONE : ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (flush) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (x_q == x1_q) begin
                    if (y_q == y1_q) begin
                        drain_d = DRAIN_LEN;
                        state_d = ST_DRAIN;
                    end else begin
                        x_d = x0_q;
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_hard) begin
        if (!reset_hard) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            drain_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            drain_q   <= drain_d;
            aborted_q <= aborted_d;
        end
    end

    bp_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (SHADE_LAT)
    ) u_delay (
        .CLOCK_50   (CLOCK_50),
        .reset_hard (reset_hard),
        .flush_i    (flush),
        .d_i        ({bus.px_valid, x_q, y_q}),
        .q_o        (dl_q)
    );

    assign {dl_valid, dl_x, dl_y} = dl_q;
    // Gating with flush also kills the result leaving the line on the abort edge itself.
    assign gun_plot_d = dl_valid & bus.sh_hit & ~flush;

    always_ff @(posedge CLOCK_50 or negedge reset_hard) begin
        if (!reset_hard) begin
            gun_plot_q  <= 1'b0;
            gun_x_q     <= '0;
            gun_y_q     <= '0;
            gun_color_q <= COL_W'(BLACK);
        end else begin
            gun_plot_q <= gun_plot_d;
            if (gun_plot_d) begin
                gun_x_q     <= dl_x;
                gun_y_q     <= dl_y;
                gun_color_q <= bus.sh_color;
            end
        end
    end

    assign bus.busy      = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.aborted   = (state_q == ST_DONE) && aborted_q;
    assign bus.px_valid  = (state_q == ST_SWEEP);
    assign bus.px_x      = x_q;
    assign bus.px_y      = y_q;
    assign bus.gun_plot  = gun_plot_q;
    assign bus.gun_x     = gun_x_q;
    assign bus.gun_y     = gun_y_q;
    assign bus.gun_color = gun_color_q;
endmodule

// File: tb/tb_bp_raster_sweeper.sv
// Directed bench for bp_raster_sweeper at shader latencies 1, 2 and 3 with a modelled shader.
module tb_bp_raster_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hit_mode = 0;
    int last_gx, last_gy, first_gx, first_gy;

    logic       st_s [3];
    logic       ab_s [3];
    logic [9:0] wx0 [3], wx1 [3];
    logic [8:0] wy0 [3], wy1 [3];
    logic       bsy [3], dn [3], abd [3], pv [3], gp [3];
    logic [9:0] pxx [3], gx [3];
    logic [8:0] pxy [3], gy [3];
    logic [2:0] gc [3];

    bp_raster_sweeper_if #(.X_W(10), .Y_W(9), .COL_W(3)) b0 ();
    bp_raster_sweeper_if #(.X_W(10), .Y_W(9), .COL_W(3)) b1 ();
    bp_raster_sweeper_if #(.X_W(10), .Y_W(9), .COL_W(3)) b2 ();

    bp_raster_sweeper #(.SHADE_LAT(1)) u_lat1 (.CLOCK_50(clk), .reset_hard(rst_n), .bus(b0.slave));
    bp_raster_sweeper #(.SHADE_LAT(2)) u_lat2 (.CLOCK_50(clk), .reset_hard(rst_n), .bus(b1.slave));
    bp_raster_sweeper #(.SHADE_LAT(3)) u_lat3 (.CLOCK_50(clk), .reset_hard(rst_n), .bus(b2.slave));

    function automatic logic hit_fn(input int mode, input logic [9:0] x);
        return (mode == 0) ? 1'b1 : x[0];
    endfunction

    function automatic logic [2:0] col_fn(input logic [9:0] x, input logic [8:0] y);
        return x[2:0] ^ {y[1:0], 1'b0};
    endfunction

    // External shader model: one pipeline per instance, length equal to its SHADE_LAT.
    logic [9:0] sp0x, sp1x [2], sp2x [3];
    logic [8:0] sp0y, sp1y [2], sp2y [3];
    always @(posedge clk) begin
        sp0x <= pxx[0];  sp0y <= pxy[0];
        sp1x[0] <= pxx[1]; sp1y[0] <= pxy[1]; sp1x[1] <= sp1x[0]; sp1y[1] <= sp1y[0];
        sp2x[0] <= pxx[2]; sp2y[0] <= pxy[2]; sp2x[1] <= sp2x[0]; sp2y[1] <= sp2y[0];
        sp2x[2] <= sp2x[1]; sp2y[2] <= sp2y[1];
    end

    assign b0.start = st_s[0]; assign b0.abort = ab_s[0];
    assign b0.win_x0 = wx0[0]; assign b0.win_x1 = wx1[0]; assign b0.win_y0 = wy0[0]; assign b0.win_y1 = wy1[0];
    assign b0.sh_hit = hit_fn(hit_mode, sp0x); assign b0.sh_color = col_fn(sp0x, sp0y);
    assign bsy[0] = b0.busy; assign dn[0] = b0.done; assign abd[0] = b0.aborted; assign pv[0] = b0.px_valid;
    assign pxx[0] = b0.px_x; assign pxy[0] = b0.px_y; assign gp[0] = b0.gun_plot;
    assign gx[0] = b0.gun_x; assign gy[0] = b0.gun_y; assign gc[0] = b0.gun_color;

    assign b1.start = st_s[1]; assign b1.abort = ab_s[1];
    assign b1.win_x0 = wx0[1]; assign b1.win_x1 = wx1[1]; assign b1.win_y0 = wy0[1]; assign b1.win_y1 = wy1[1];
    assign b1.sh_hit = hit_fn(hit_mode, sp1x[1]); assign b1.sh_color = col_fn(sp1x[1], sp1y[1]);
    assign bsy[1] = b1.busy; assign dn[1] = b1.done; assign abd[1] = b1.aborted; assign pv[1] = b1.px_valid;
    assign pxx[1] = b1.px_x; assign pxy[1] = b1.px_y; assign gp[1] = b1.gun_plot;
    assign gx[1] = b1.gun_x; assign gy[1] = b1.gun_y; assign gc[1] = b1.gun_color;

    assign b2.start = st_s[2]; assign b2.abort = ab_s[2];
    assign b2.win_x0 = wx0[2]; assign b2.win_x1 = wx1[2]; assign b2.win_y0 = wy0[2]; assign b2.win_y1 = wy1[2];
    assign b2.sh_hit = hit_fn(hit_mode, sp2x[2]); assign b2.sh_color = col_fn(sp2x[2], sp2y[2]);
    assign bsy[2] = b2.busy; assign dn[2] = b2.done; assign abd[2] = b2.aborted; assign pv[2] = b2.px_valid;
    assign pxx[2] = b2.px_x; assign pxy[2] = b2.px_y; assign gp[2] = b2.gun_plot;
    assign gx[2] = b2.gun_x; assign gy[2] = b2.gun_y; assign gc[2] = b2.gun_color;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a sweep on instance i and follows it to done, comparing px_* and gun_* against a raster walk.
    task automatic run_sweep(input int i, input int x0, input int x1, input int y0, input int y1,
                             input int abort_at, input int budget,
                             output int done_rel, output int ab_seen, output int n_pv,
                             output int n_gp, output int bad);
        int lat = i + 1;
        int cx0 = (x0 > 319) ? 319 : x0;
        int cx1 = (x1 > 319) ? 319 : x1;
        int cy0 = (y0 > 239) ? 239 : y0;
        int cy1 = (y1 > 239) ? 239 : y1;
        int mx = cx0, my = cy0, pk = 1;
        int gmx = cx0, gmy = cy0, gk = 1;
        done_rel = 0; ab_seen = 0; n_pv = 0; n_gp = 0; bad = 0;
        @(negedge clk);
        wx0[i] = 10'(x0); wx1[i] = 10'(x1); wy0[i] = 9'(y0); wy1[i] = 9'(y1);
        st_s[i] = 1'b1;
        @(negedge clk);
        st_s[i] = 1'b0;
        for (int rel = 1; rel <= budget && done_rel == 0; rel++) begin
            if (rel > 1) @(negedge clk);
            ab_s[i] = (rel == abort_at);
            if (pv[i]) begin
                n_pv++;
                if (int'(pxx[i]) != mx || int'(pxy[i]) != my || rel != pk) bad++;
                if (mx == cx1) begin mx = cx0; my++; end else mx++;
                pk++;
            end
            if (gp[i]) begin
                n_gp++;
                while (gmy <= cy1 && !hit_fn(hit_mode, 10'(gmx))) begin
                    if (gmx == cx1) begin gmx = cx0; gmy++; end else gmx++;
                    gk++;
                end
                if (gmy > cy1 || int'(gx[i]) != gmx || int'(gy[i]) != gmy ||
                    gc[i] != col_fn(10'(gmx), 9'(gmy)) || rel != gk + lat + 1) bad++;
                if (n_gp == 1) begin first_gx = int'(gx[i]); first_gy = int'(gy[i]); end
                last_gx = int'(gx[i]); last_gy = int'(gy[i]);
                if (gmx == cx1) begin gmx = cx0; gmy++; end else gmx++;
                gk++;
            end
            if (dn[i]) begin
                done_rel = rel;
                ab_seen  = int'(abd[i]);
                if (bsy[i]) bad++;
            end else if (!bsy[i]) begin
                bad++;
            end
        end
        ab_s[i] = 1'b0;
    endtask

    initial begin
        int d, a, npv, ngp, bad, dcount;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_s[i] = 1'b0; ab_s[i] = 1'b0;
            wx0[i] = '0; wx1[i] = '0; wy0[i] = '0; wy1[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_busy", bsy[0], 0);
        check_val("rst_done", dn[0], 0);
        check_val("rst_pxvalid", pv[0], 0);
        check_val("rst_plot", gp[0], 0);
        check_val("rst_aborted", abd[1], 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 0, 319, 0, 239, 0, 80000, d, a, npv, ngp, bad);
        check_val("t1_done_cycle", d, 76803);
        check_val("t1_aborted", a, 0);
        check_val("t1_px_count", npv, 76800);
        check_val("t1_plot_count", ngp, 76800);
        check_val("t1_order", bad, 0);
        check_val("t1_last_x", last_gx, 319);
        check_val("t1_last_y", last_gy, 239);

        hit_mode = 1;
        run_sweep(2, 10, 13, 20, 21, 0, 50, d, a, npv, ngp, bad);
        check_val("t2_done_cycle", d, 13);
        check_val("t2_plot_count", ngp, 4);
        check_val("t2_order", bad, 0);
        check_val("t2_first_x", first_gx, 11);
        check_val("t2_first_y", first_gy, 20);
        check_val("t2_last_x", last_gx, 13);
        check_val("t2_last_y", last_gy, 21);
        hit_mode = 0;

        run_sweep(0, 300, 400, 230, 300, 0, 400, d, a, npv, ngp, bad);
        check_val("t3_done_cycle", d, 203);
        check_val("t3_plot_count", ngp, 200);
        check_val("t3_order", bad, 0);
        check_val("t3_last_x", last_gx, 319);
        check_val("t3_last_y", last_gy, 239);

        run_sweep(0, 50, 40, 0, 0, 0, 10, d, a, npv, ngp, bad);
        check_val("t4_done_cycle", d, 1);
        check_val("t4_aborted", a, 0);
        check_val("t4_px_count", npv, 0);
        check_val("t4_plot_count", ngp, 0);

        run_sweep(1, 0, 7, 0, 7, 5, 100, d, a, npv, ngp, bad);
        check_val("t5_done_cycle", d, 6);
        check_val("t5_aborted", a, 1);
        check_val("t5_plot_count", ngp, 2);
        check_val("t5_order", bad, 0);
        run_sweep(1, 5, 6, 5, 5, 0, 20, d, a, npv, ngp, bad);
        check_val("t5_restart_done", d, 6);
        check_val("t5_restart_aborted", a, 0);
        check_val("t5_restart_plots", ngp, 2);

        @(negedge clk);
        wx0[0] = 10'd0; wx1[0] = 10'd99; wy0[0] = 9'd0; wy1[0] = 9'd0;
        st_s[0] = 1'b1;
        @(negedge clk);
        st_s[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t6_pre_plot", gp[0], 1);
        check_val("t6_pre_busy", bsy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_busy", bsy[0], 0);
        check_val("t6_pxvalid", pv[0], 0);
        check_val("t6_px_x", pxx[0], 0);
        check_val("t6_plot", gp[0], 0);
        check_val("t6_gun_x", gx[0], 0);
        dcount = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dn[0]) dcount++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dn[0]) dcount++;
        end
        check_val("t6_no_done", dcount, 0);
        run_sweep(0, 2, 4, 3, 3, 0, 20, d, a, npv, ngp, bad);
        check_val("t6_fresh_done", d, 6);
        check_val("t6_fresh_plots", ngp, 3);
        check_val("t6_fresh_order", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
